attack_coprocessor: RTL



---
 rtl/attack_coprocessor.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/attack_coprocessor.sv
// Per-player attack engine: button edge -> windup/active/stun/cooldown FSM, hitbox test, victim damage and knockback.
// Latency: start at edge N, ACTIVE at N+WINDUP_CYCLES, earliest attack_out/hit_pulse at N+WINDUP_CYCLES+1; all outputs registered.
// No backpressure; freeze_in stalls the FSM, counters and held outputs, button edges outside IDLE are dropped.
module attack_coprocessor #(
    parameter int WINDUP_CYCLES   = 4,
    parameter int ACTIVE_CYCLES   = 8,
    parameter int STUN_CYCLES     = 16,
    parameter int COOLDOWN_CYCLES = 8,
    parameter int RANGE_X         = 40,
    parameter int RANGE_Y         = 30,
    parameter int DAMAGE_PER_HIT  = 10,
    parameter int DAMAGE_MAX      = 999,
    parameter int KB_BASE_X       = 256,
    parameter int KB_BASE_Y       = 128,
    parameter int KB_SCALE        = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        attack_btn,
    input  logic [31:0] attacker_controller,
    input  logic [31:0] attacker_position,
    input  logic [31:0] victim_position,
    input  logic        freeze_in,
    output logic        attack_out,
    output logic [31:0] knockback_out,
    output logic        hit_pulse,
    output logic        busy,
    output logic [9:0]  damage
);

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WINDUP,
        S_ACTIVE,
        S_STUN,
        S_COOLDOWN
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               btn_prev_q;
    logic               facing_q;
    logic               attack_q;
    logic [31:0]        knockback_q;
    logic               hit_pulse_q;
    logic               busy_q;
    logic [9:0]         damage_q;

    // Only the joystick sign bit matters here; the rest of the controller word is ignored.
    logic unused_ctrl;
    assign unused_ctrl = ^{attacker_controller[31:16], attacker_controller[14:0]};

    // Hitbox geometry: 17-bit signed deltas so any pair of 16-bit positions is representable.
    logic signed [16:0] dx;
    logic signed [16:0] dy;
    logic [16:0]        adx;
    logic [16:0]        ady;
    logic               dir_ok;
    logic               hit_now;

    assign dx      = $signed({1'b0, victim_position[31:16]}) - $signed({1'b0, attacker_position[31:16]});
    assign dy      = $signed({1'b0, victim_position[15:0]})  - $signed({1'b0, attacker_position[15:0]});
    assign adx     = dx[16] ? unsigned'(-dx) : unsigned'(dx);
    assign ady     = dy[16] ? unsigned'(-dy) : unsigned'(dy);
    // Facing right accepts victims at or ahead of us; facing left accepts at or behind. dx==0 passes both.
    assign dir_ok  = facing_q ? ~dx[16] : (dx[16] | (dx == 17'sd0));
    assign hit_now = (adx <= 17'(RANGE_X)) && (ady <= 17'(RANGE_Y)) && dir_ok;

    // Damage after a hit, saturating at DAMAGE_MAX.
    logic [10:0] dmg_sum;
    logic [9:0]  damage_d;

    assign dmg_sum  = {1'b0, damage_q} + 11'(DAMAGE_PER_HIT);
    assign damage_d = (dmg_sum > 11'(DAMAGE_MAX)) ? 10'(DAMAGE_MAX) : dmg_sum[9:0];

    // Knockback magnitudes scale with the post-hit damage; each axis saturates to the largest positive int16.
    logic [31:0] mag_x;
    logic [31:0] mag_y;
    logic [15:0] mag_x_sat;
    logic [15:0] mag_y_sat;
    logic [15:0] kb_x;
    logic [31:0] knockback_d;

    assign mag_x       = 32'(KB_BASE_X) + {22'd0, damage_d} * 32'(KB_SCALE);
    assign mag_y       = 32'(KB_BASE_Y) + {22'd0, damage_d} * 32'(KB_SCALE / 2);
    assign mag_x_sat   = (mag_x > 32'd32767) ? 16'h7FFF : mag_x[15:0];
    assign mag_y_sat   = (mag_y > 32'd32767) ? 16'h7FFF : mag_y[15:0];
    assign kb_x        = facing_q ? mag_x_sat : 16'(16'd0 - mag_x_sat);
    assign knockback_d = {kb_x, mag_y_sat};

    logic btn_rise;
    assign btn_rise = attack_btn & ~btn_prev_q;

    // Attack FSM with registered outputs; freeze holds everything except the button history and the hit pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            btn_prev_q  <= 1'b0;
            facing_q    <= 1'b0;
            attack_q    <= 1'b0;
            knockback_q <= '0;
            hit_pulse_q <= 1'b0;
            busy_q      <= 1'b0;
            damage_q    <= '0;
        end else begin
            btn_prev_q  <= attack_btn;
            hit_pulse_q <= 1'b0;
            if (!freeze_in) begin
                case (state_q)
                    S_IDLE: begin
                        if (btn_rise) begin
                            state_q  <= S_WINDUP;
                            cnt_q    <= '0;
                            facing_q <= attacker_controller[15];
                            busy_q   <= 1'b1;
                        end
                    end
                    S_WINDUP: begin
                        if (cnt_q == CNT_W'(WINDUP_CYCLES - 1)) begin
                            state_q <= S_ACTIVE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    S_ACTIVE: begin
                        if (hit_now) begin
                            state_q     <= S_STUN;
                            cnt_q       <= '0;
                            attack_q    <= 1'b1;
                            knockback_q <= knockback_d;
                            damage_q    <= damage_d;
                            hit_pulse_q <= 1'b1;
                        end else if (cnt_q == CNT_W'(ACTIVE_CYCLES - 1)) begin
                            state_q <= S_COOLDOWN;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    S_STUN: begin
                        if (cnt_q == CNT_W'(STUN_CYCLES - 1)) begin
                            state_q     <= S_COOLDOWN;
                            cnt_q       <= '0;
                            attack_q    <= 1'b0;
                            knockback_q <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    S_COOLDOWN: begin
                        if (cnt_q == CNT_W'(COOLDOWN_CYCLES - 1)) begin
                            state_q <= S_IDLE;
                            cnt_q   <= '0;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q     <= S_IDLE;
                        cnt_q       <= '0;
                        attack_q    <= 1'b0;
                        knockback_q <= '0;
                        busy_q      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign attack_out    = attack_q;
    assign knockback_out = knockback_q;
    assign hit_pulse     = hit_pulse_q;
    assign busy          = busy_q;
    assign damage        = damage_q;

endmodule
